vga_timing_gen: RTL and testbench

Parametrised VGA timing and pixel-output generator for the CPU top level. It produces h_sync/v_sync and blanked RGB from a pixel-clock enable derived from clk_in. Successor to the fixed 640x480, 2-bit-per-colour video path: resolution, porches, sync polarity, colour depth and clock divide are all parameters. It also provides pixel coordinates and frame/line strobes, so a framebuffer or the CPU can supply pixel data one pixel ahead.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/vga_axis_counter.sv | 50 +++++
 rtl/vga_timing_gen.sv | 99 +++++++++
 tb/tb_vga_timing_gen.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and elaboration helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP} phase_e;

  // Minimum of 1 so that a degenerate count still gets a legal vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle between the timing generator (master) and a pixel source / display (slave).
// The master asks for pixel data at px_x/px_y and returns blanked colour plus syncs.
interface vga_timing_gen_if #(
  parameter int COLOR_BITS = 2,
  parameter int XW         = 10,
  parameter int YW         = 10
);
  logic [COLOR_BITS-1:0] pix_r, pix_g, pix_b;
  logic [COLOR_BITS-1:0] red, green, blue;
  logic [XW-1:0]         px_x;
  logic [YW-1:0]         px_y;
  logic                  px_req, line_start, frame_start, h_sync, v_sync;

  modport master (
    input  pix_r, pix_g, pix_b,
    output px_x, px_y, px_req, line_start, frame_start, h_sync, v_sync, red, green, blue
  );

  modport slave (
    output pix_r, pix_g, pix_b,
    input  px_x, px_y, px_req, line_start, frame_start, h_sync, v_sync, red, green, blue
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One video axis: wrapping position counter with active/sync phase decode.
// Count advances on the edge where en is high; o_wrap is combinational; no backpressure.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int TOTAL  = axis_total(ACTIVE, FP, SYNC, BP),
  parameter int W      = clog2(TOTAL)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap,
  output logic         o_in_active,
  output logic         o_in_sync
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] r_cnt;
  phase_e       w_phase;

  always_ff @(posedge clk_in) begin
    if (rst_in)
      r_cnt <= '0;
    else if (en)
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  // Compared as int so a boundary equal to TOTAL cannot truncate into range.
  always_comb begin
    w_phase = PH_BP;
    if (int'(r_cnt) < ACTIVE)
      w_phase = PH_ACTIVE;
    else if (int'(r_cnt) < ACTIVE + FP)
      w_phase = PH_FP;
    else if (int'(r_cnt) < ACTIVE + FP + SYNC)
      w_phase = PH_SYNC;
  end

  assign o_cnt       = r_cnt;
  assign o_wrap      = en && (r_cnt == LAST);
  assign o_in_active = (w_phase == PH_ACTIVE);
  assign o_in_sync   = (w_phase == PH_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing: pixel-enable divider, h/v counters, registered sync and blanked colour.
// Colour/sync appear one clk_in edge after the pix_en cycle that sampled them; no backpressure.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CLK_DIV    = 2,
  parameter int COLOR_BITS = 2,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int XW      = clog2(H_TOTAL);
  localparam int YW      = clog2(V_TOTAL);
  localparam int DW      = clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]         r_div;
  logic                  w_pix_en, w_h_wrap, w_v_wrap;
  logic                  w_h_act, w_v_act, w_h_sync, w_v_sync, w_active;
  logic [XW-1:0]         w_h_cnt;
  logic [YW-1:0]         w_v_cnt;
  logic                  r_hs, r_vs, r_line, r_frame;
  logic [COLOR_BITS-1:0] r_red, r_green, r_blue;

  // With CLK_DIV=1 DIV_LAST is 0, so pix_en stays high outside reset.
  always_ff @(posedge clk_in) begin
    if (rst_in || r_div == DIV_LAST)
      r_div <= '0;
    else
      r_div <= r_div + 1'b1;
  end

  assign w_pix_en = (r_div == DIV_LAST) && !rst_in;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk_in(clk_in), .rst_in(rst_in), .en(w_pix_en),
    .o_cnt(w_h_cnt), .o_wrap(w_h_wrap), .o_in_active(w_h_act), .o_in_sync(w_h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk_in(clk_in), .rst_in(rst_in), .en(w_h_wrap),
    .o_cnt(w_v_cnt), .o_wrap(w_v_wrap), .o_in_active(w_v_act), .o_in_sync(w_v_sync)
  );

  assign w_active = w_h_act && w_v_act;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      // v wrap already implies an h wrap on a pix_en cycle.
      r_line  <= w_h_wrap;
      r_frame <= w_v_wrap;
      if (w_pix_en) begin
        r_hs    <= w_h_sync ? HS_POL : ~HS_POL;
        r_vs    <= w_v_sync ? VS_POL : ~VS_POL;
        r_red   <= w_active ? vif.pix_r : '0;
        r_green <= w_active ? vif.pix_g : '0;
        r_blue  <= w_active ? vif.pix_b : '0;
      end
    end
  end

  assign vif.px_x        = w_h_cnt;
  assign vif.px_y        = w_v_cnt;
  assign vif.px_req      = w_pix_en && w_active;
  assign vif.line_start  = r_line;
  assign vif.frame_start = r_frame;
  assign vif.h_sync      = r_hs;
  assign vif.v_sync      = r_vs;
  assign vif.red         = r_red;
  assign vif.green       = r_green;
  assign vif.blue        = r_blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three generator configurations driven with random pixel data and mid-frame resets,
// each checked every cycle against a closed-form timing model through a scoreboard queue.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int NCYC = 6000;

  typedef struct { int x, y, req, ls, fs, hs, vs, r, g, b; } obs_t;
  typedef struct { int cyc; obs_t o; } exp_t;
  typedef struct { int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, div, hpol, vpol, cb; } cfg_t;

  logic clk_in;
  logic rst0, rst1, rst2;

  cfg_t cfg[3];
  int   mt[3];
  int   mr[3], mg[3], mb[3];
  bit   seen[3];
  int   rs_at[3], rs_len[3];
  exp_t sbq[3][$];
  int   cyc;
  int   total, bad;

  vga_timing_gen_if #(.COLOR_BITS(2), .XW(clog2(15)), .YW(clog2(8)))  if0 ();
  vga_timing_gen_if #(.COLOR_BITS(3), .XW(clog2(10)), .YW(clog2(7)))  if1 ();
  vga_timing_gen_if #(.COLOR_BITS(2), .XW(clog2(800)), .YW(clog2(525))) if2 ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .COLOR_BITS(2), .HS_POL(1'b0), .VS_POL(1'b0)
  ) u0 (.clk_in(clk_in), .rst_in(rst0), .vif(if0));

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(3), .COLOR_BITS(3), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u1 (.clk_in(clk_in), .rst_in(rst1), .vif(if1));

  vga_timing_gen u2 (.clk_in(clk_in), .rst_in(rst2), .vif(if2));

  initial clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  task automatic chk(input string nm, input int i, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s inst=%0d cyc=%0d got=%0d expected=%0d", nm, i, cyc, act, want);
    end
  endtask

  // Expected outputs during the current cycle, from t = edges since the last reset edge.
  function automatic obs_t model_out(input int i, input bit rn);
    obs_t o;
    cfg_t c;
    int ht, ft, t, p, n, m, hx, vy;
    c  = cfg[i];
    t  = mt[i];
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    ft = ht * (c.va + c.vfp + c.vsw + c.vbp);
    p  = t / c.div;
    n  = p % ft;
    o.x   = n % ht;
    o.y   = n / ht;
    o.req = (!rn && ((t + 1) % c.div == 0) && o.x < c.ha && o.y < c.va) ? 1 : 0;
    o.ls  = (t > 0 && t % c.div == 0 && o.x == 0) ? 1 : 0;
    o.fs  = (o.ls == 1 && o.y == 0) ? 1 : 0;
    if (p == 0) begin
      o.hs = 1 - c.hpol;
      o.vs = 1 - c.vpol;
    end else begin
      m  = (p - 1) % ft;
      hx = m % ht;
      vy = m / ht;
      o.hs = (hx >= c.ha + c.hfp && hx < c.ha + c.hfp + c.hsw) ? c.hpol : 1 - c.hpol;
      o.vs = (vy >= c.va + c.vfp && vy < c.va + c.vfp + c.vsw) ? c.vpol : 1 - c.vpol;
    end
    o.r = mr[i];
    o.g = mg[i];
    o.b = mb[i];
    return o;
  endfunction

  task automatic step(input int i, input bit rn, input int r, input int g, input int b);
    int ht, p, n, x, y;
    if (rn) begin
      mt[i] = 0; mr[i] = 0; mg[i] = 0; mb[i] = 0; seen[i] = 1'b1;
    end else if (seen[i]) begin
      if ((mt[i] + 1) % cfg[i].div == 0) begin
        ht = cfg[i].ha + cfg[i].hfp + cfg[i].hsw + cfg[i].hbp;
        p  = mt[i] / cfg[i].div;
        n  = p % (ht * (cfg[i].va + cfg[i].vfp + cfg[i].vsw + cfg[i].vbp));
        x  = n % ht;
        y  = n / ht;
        if (x < cfg[i].ha && y < cfg[i].va) begin
          mr[i] = r; mg[i] = g; mb[i] = b;
        end else begin
          mr[i] = 0; mg[i] = 0; mb[i] = 0;
        end
      end
      mt[i]++;
    end
  endtask

  task automatic drive(input int i, input bit rn, input int r, input int g, input int b);
    case (i)
      0: begin rst0 = rn; if0.pix_r = r[1:0]; if0.pix_g = g[1:0]; if0.pix_b = b[1:0]; end
      1: begin rst1 = rn; if1.pix_r = r[2:0]; if1.pix_g = g[2:0]; if1.pix_b = b[2:0]; end
      default: begin rst2 = rn; if2.pix_r = r[1:0]; if2.pix_g = g[1:0]; if2.pix_b = b[1:0]; end
    endcase
  endtask

  task automatic sample(input int i, output obs_t o);
    case (i)
      0: o = '{int'(if0.px_x), int'(if0.px_y), int'(if0.px_req), int'(if0.line_start),
               int'(if0.frame_start), int'(if0.h_sync), int'(if0.v_sync),
               int'(if0.red), int'(if0.green), int'(if0.blue)};
      1: o = '{int'(if1.px_x), int'(if1.px_y), int'(if1.px_req), int'(if1.line_start),
               int'(if1.frame_start), int'(if1.h_sync), int'(if1.v_sync),
               int'(if1.red), int'(if1.green), int'(if1.blue)};
      default: o = '{int'(if2.px_x), int'(if2.px_y), int'(if2.px_req), int'(if2.line_start),
               int'(if2.frame_start), int'(if2.h_sync), int'(if2.v_sync),
               int'(if2.red), int'(if2.green), int'(if2.blue)};
    endcase
  endtask

  function automatic bit want_rst(input int i, input int c);
    return (c < 4) || (c >= rs_at[i] && c < rs_at[i] + rs_len[i]);
  endfunction

  // Monitor: pops one expectation per instance per cycle and compares every output.
  always @(negedge clk_in) begin
    exp_t e;
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      if (sbq[i].size() > 0) begin
        e = sbq[i].pop_front();
        sample(i, o);
        chk("sb_cycle", i, e.cyc, cyc);
        chk("px_x", i, o.x, e.o.x);
        chk("px_y", i, o.y, e.o.y);
        chk("px_req", i, o.req, e.o.req);
        chk("line_start", i, o.ls, e.o.ls);
        chk("frame_start", i, o.fs, e.o.fs);
        chk("h_sync", i, o.hs, e.o.hs);
        chk("v_sync", i, o.vs, e.o.vs);
        chk("red", i, o.r, e.o.r);
        chk("green", i, o.g, e.o.g);
        chk("blue", i, o.b, e.o.b);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    cfg[0] = '{8, 2, 3, 2, 4, 1, 2, 1, 1, 0, 0, 2};
    cfg[1] = '{6, 1, 2, 1, 3, 1, 1, 2, 3, 1, 1, 3};
    cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 0, 2};
    rs_at[0] = 2000 + int'($urandom_range(0, 119));
    rs_at[1] = 2600 + int'($urandom_range(0, 209));
    rs_at[2] = 3500 + int'($urandom_range(0, 99));
    for (int i = 0; i < 3; i++) begin
      rs_len[i] = int'($urandom_range(1, 3));
      mt[i] = 0; mr[i] = 0; mg[i] = 0; mb[i] = 0; seen[i] = 1'b0;
      drive(i, 1'b1, 0, 0, 0);
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk_in);
      #1;
      cyc = c;
      for (int i = 0; i < 3; i++) begin
        bit   rn;
        int   r, g, b, cmax;
        exp_t e;
        rn   = want_rst(i, c);
        cmax = (1 << cfg[i].cb) - 1;
        r    = int'($urandom_range(0, cmax));
        g    = int'($urandom_range(0, cmax));
        b    = int'($urandom_range(0, cmax));
        drive(i, rn, r, g, b);
        if (seen[i]) begin
          e.cyc = c;
          e.o   = model_out(i, rn);
          sbq[i].push_back(e);
        end
        step(i, rn, r, g, b);
      end
    end

    @(negedge clk_in);
    #1;
    for (int i = 0; i < 3; i++)
      chk("sb_drain", i, sbq[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
